// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit_pkg
//  Purpose  : Shared CPU-internal widths and fetch FSM state encoding used by
//             the fetch unit, its bus interface and anything probing its state.
//  Revision : 1.0  initial release
// ============================================================================
package instr_fetch_unit_pkg;

    // CPU-internal datapath widths
    localparam int CPU_PC_N    = 8;
    localparam int CPU_INSTR_N = 16;
    localparam int FETCH_DEPTH = 2;

    // Fetch FSM states.
    //   IDLE  : no request outstanding
    //   WAIT  : request outstanding, its data will be kept
    //   DRAIN : request outstanding but flushed; its data will be dropped
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit_if
//  Purpose  : Bus bundle between the PC register, instruction memory, the
//             fetch unit and the decoder.
//  Ports    : PC/Flush/PcAdvance   - PC register side
//             ImemReq/Addr/Ack/Data - instruction memory read port
//             InstrValid/Instr/InstrPC/InstrReady - decoder handshake
//  Modports : master = fetch unit, slave = surrounding system
//  Revision : 1.0  initial release
// ============================================================================
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_N    = CPU_PC_N,
    parameter int INSTR_N = CPU_INSTR_N
);
    logic [PC_N-1:0]    PC;
    logic               Flush;
    logic               PcAdvance;
    logic               ImemReq;
    logic [PC_N-1:0]    ImemAddr;
    logic               ImemAck;
    logic [INSTR_N-1:0] ImemData;
    logic               InstrValid;
    logic [INSTR_N-1:0] Instr;
    logic [PC_N-1:0]    InstrPC;
    logic               InstrReady;

    modport master (
        input  PC, Flush, ImemAck, ImemData, InstrReady,
        output PcAdvance, ImemReq, ImemAddr, InstrValid, Instr, InstrPC
    );

    modport slave (
        output PC, Flush, ImemAck, ImemData, InstrReady,
        input  PcAdvance, ImemReq, ImemAddr, InstrValid, Instr, InstrPC
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Synchronous in-order FIFO holding fetched {PC, instruction}
//             pairs. Flush empties it in one edge; storage is not cleared by
//             flush, only the pointers and the count.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             i_push/i_data   - write one entry (never issued when full)
//             i_pop           - drop head entry (never issued when empty)
//             i_flush         - discard all entries, overrides push/pop
//             o_count         - occupancy 0..DEPTH
//             o_head          - head entry, straight from storage
//  Revision : 1.0  initial release
// ============================================================================
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int WIDTH = CPU_PC_N + CPU_INSTR_N,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_push,
    input  wire logic               i_pop,
    input  wire logic               i_flush,
    input  wire logic [WIDTH-1:0]   i_data,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic [WIDTH-1:0]        o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Fetch stage after the PC register. Issues one instruction
//             memory read at a time, buffers returned {PC, instr} pairs and
//             hands them to the decoder. PcAdvance steps the PC register only
//             when a fetch completes; Flush drops buffered and in-flight work.
//  Ports    : Clock, Reset - clock, synchronous active-high reset
//             bus (master) - PC register, instruction memory and decoder
//                            signals, see instr_fetch_unit_if
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_N    = CPU_PC_N,
    parameter int INSTR_N = CPU_INSTR_N,
    parameter int DEPTH   = FETCH_DEPTH
) (
    input  wire logic           Clock,
    input  wire logic           Reset,
    instr_fetch_unit_if.master  bus
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    fetch_state_t             r_state;
    logic                     r_req;
    logic [PC_N-1:0]          r_addr;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_valid;
    logic [CW-1:0]            w_count;
    logic [PC_N+INSTR_N-1:0]  w_head;

    // Only a non-flushed completion in WAIT is kept. The Reset term keeps the
    // PC register from stepping in a cycle whose result is being discarded.
    assign w_push  = (r_state == ST_WAIT) & bus.ImemAck & ~bus.Flush & ~Reset;
    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid & bus.InstrReady;

    fetch_fifo #(
        .WIDTH (PC_N + INSTR_N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (Clock),
        .rst     (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.Flush),
        .i_data  ({r_addr, bus.ImemData}),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // A request cannot be withdrawn once issued: a flush while waiting moves
    // to DRAIN, which keeps ImemReq up and throws the data away on ack.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!bus.Flush && (w_count < C_DEPTH)) begin
                        r_state <= ST_WAIT;
                        r_req   <= 1'b1;
                        r_addr  <= bus.PC;
                    end
                end
                ST_WAIT: begin
                    if (bus.ImemAck) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end else if (bus.Flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.ImemAck) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PcAdvance  = w_push;
    assign bus.ImemReq    = r_req;
    assign bus.ImemAddr   = r_addr;
    assign bus.InstrValid = w_valid;
    assign bus.InstrPC    = w_head[PC_N+INSTR_N-1:INSTR_N];
    assign bus.Instr      = w_head[INSTR_N-1:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Self-checking bench for instr_fetch_unit: directed scenarios
//             followed by randomized traffic, compared every cycle against a
//             queue-based model of the fetch/buffer behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int PC_N    = 8;
    localparam int INSTR_N = 16;
    localparam int DEPTH   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.PC_N(PC_N), .INSTR_N(INSTR_N)) bus ();

    instr_fetch_unit #(.PC_N(PC_N), .INSTR_N(INSTR_N), .DEPTH(DEPTH)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [PC_N-1:0]    pc;
        logic [INSTR_N-1:0] ins;
    } entry_t;

    logic [INSTR_N-1:0] mem [256];
    entry_t fifo_q[$];
    entry_t consumed[$];
    bit              outstanding = 0;   // a read is in flight
    bit              doomed      = 0;   // in-flight read was flushed
    bit              fresh       = 1;   // nothing pushed since reset
    logic [PC_N-1:0] req_addr    = '0;
    logic [PC_N-1:0] last_addr   = '0;
    logic [PC_N-1:0] pc_m        = '0;
    logic [PC_N-1:0] flush_tgt   = '0;
    int              wait_cnt    = 0;
    int              lat_cur     = 0;
    int              fixed_lat   = 1;
    int              p_ready     = 100;
    int              p_flush     = 0;
    bit              force_flush = 0;
    logic [PC_N-1:0] force_target = '0;
    bit              stray_ack   = 0;
    int              pcadv_pulses = 0;
    int              accepts      = 0;

    // Compare registered outputs, then drive the next inputs, then compare
    // the combinational PcAdvance against those inputs.
    always @(negedge clk) begin : b_drive_check
        fetch_state_t exp_state;
        exp_state = outstanding ? (doomed ? ST_DRAIN : ST_WAIT) : ST_IDLE;
        chk("ImemReq", bus.ImemReq, outstanding);
        chk("ImemAddr", bus.ImemAddr, last_addr);
        chk("InstrValid", bus.InstrValid, fifo_q.size() > 0);
        if (fifo_q.size() > 0) begin
            chk("InstrPC", bus.InstrPC, fifo_q[0].pc);
            chk("Instr", bus.Instr, fifo_q[0].ins);
        end else if (fresh) begin
            chk("InstrPC_reset", bus.InstrPC, 0);
            chk("Instr_reset", bus.Instr, 0);
        end
        chk("state", dut.r_state, exp_state);

        bus.PC         = pc_m;
        bus.InstrReady = ($urandom_range(99) < p_ready);
        if (force_flush) begin
            bus.Flush   = 1'b1;
            flush_tgt   = force_target;
            force_flush = 0;
        end else begin
            bus.Flush = ($urandom_range(99) < p_flush);
            flush_tgt = PC_N'($urandom);
        end
        bus.ImemAck  = stray_ack || (outstanding && wait_cnt >= lat_cur);
        stray_ack    = 0;
        bus.ImemData = bus.ImemAck ? mem[req_addr] : INSTR_N'($urandom);
        #1;
        chk("PcAdvance", bus.PcAdvance,
            outstanding && !doomed && bus.ImemAck && !bus.Flush && !rst);
    end

    always @(posedge clk) begin : b_model
        bit acc, pop, issue;
        int sz;
        sz  = fifo_q.size();
        acc = outstanding && !doomed && bus.ImemAck && !bus.Flush && !rst;
        pop = (sz > 0) && bus.InstrReady;
        if (bus.PcAdvance) pcadv_pulses++;
        if (dut.w_push) chk("push_when_full", dut.w_count == DEPTH, 0);
        if (rst) begin
            fifo_q.delete();
            outstanding = 0;
            doomed      = 0;
            last_addr   = '0;
            pc_m        = '0;
            wait_cnt    = 0;
            fresh       = 1;
        end else begin
            issue = !outstanding && !bus.Flush && (sz < DEPTH);
            if (pop) consumed.push_back(fifo_q[0]);
            if (outstanding) begin
                if (bus.ImemAck) begin
                    outstanding = 0;
                    doomed      = 0;
                end else begin
                    if (bus.Flush) doomed = 1;
                    wait_cnt++;
                end
            end
            if (bus.Flush) begin
                fifo_q.delete();
            end else begin
                if (pop) void'(fifo_q.pop_front());
                if (acc) begin
                    fifo_q.push_back('{req_addr, mem[req_addr]});
                    fresh = 0;
                    accepts++;
                end
            end
            if (issue) begin
                outstanding = 1;
                doomed      = 0;
                req_addr    = pc_m;
                last_addr   = pc_m;
                wait_cnt    = 0;
                lat_cur     = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            if (bus.Flush)  pc_m = flush_tgt;
            else if (acc)   pc_m = pc_m + 1'b1;
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        consumed.delete();
    endtask

    task automatic chk_consumed(input string name, input int idx,
                                input logic [PC_N-1:0] pc, input logic [INSTR_N-1:0] ins);
        if (idx >= consumed.size()) begin
            chk(name, 32'hFFFF_FFFF, {pc, ins});
        end else begin
            chk(name, {consumed[idx].pc, consumed[idx].ins}, {pc, ins});
        end
    endtask

    task automatic wait_issue_at_count(input int cnt, input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            if (fifo_q.size() == cnt && outstanding && !doomed && wait_cnt == 0) break;
            cyc(1);
        end
        if (i == 40) timeout_fail(name);
    endtask

    initial begin : b_main
        int p0;
        int i;
        bus.PC = '0; bus.Flush = 1'b0; bus.ImemAck = 1'b0;
        bus.ImemData = '0; bus.InstrReady = 1'b0;
        for (int k = 0; k < 256; k++) mem[k] = INSTR_N'(16'h1000 + k);

        // Reset state and streaming
        fixed_lat = 1; p_ready = 100; p_flush = 0;
        cyc(1);
        do_reset();
        chk("rst_ImemReq", bus.ImemReq, 0);
        chk("rst_ImemAddr", bus.ImemAddr, 0);
        chk("rst_InstrValid", bus.InstrValid, 0);
        chk("rst_Instr", bus.Instr, 0);
        chk("rst_InstrPC", bus.InstrPC, 0);
        p0 = pcadv_pulses;
        i  = accepts;
        cyc(20);
        chk_consumed("stream_0", 0, 8'h00, 16'h1000);
        chk_consumed("stream_1", 1, 8'h01, 16'h1001);
        chk_consumed("stream_2", 2, 8'h02, 16'h1002);
        chk("stream_pulses_per_ack", pcadv_pulses - p0, accepts - i);

        // Backpressure fills the buffer and stalls issue
        p_ready = 0;
        do_reset();
        cyc(15);
        chk("bp_count", dut.w_count, DEPTH);
        chk("bp_ImemReq", bus.ImemReq, 0);
        chk("bp_head_pc", bus.InstrPC, 8'h00);
        p_ready = 100;
        cyc(15);
        chk_consumed("bp_pop0", 0, 8'h00, 16'h1000);
        chk_consumed("bp_pop1", 1, 8'h01, 16'h1001);
        chk_consumed("bp_pop2", 2, 8'h02, 16'h1002);

        // Flush while waiting, ack three cycles later
        fixed_lat = 100;
        do_reset();
        wait_issue_at_count(0, "wait_flush_issue");
        fixed_lat    = 1;
        lat_cur      = wait_cnt + 3;
        force_flush  = 1;
        force_target = 8'h40;
        p0 = pcadv_pulses;
        cyc(1);
        chk("drain_state", dut.r_state, ST_DRAIN);
        chk("drain_req", bus.ImemReq, 1);
        cyc(1);
        chk("drain_req_held", bus.ImemReq, 1);
        for (i = 0; i < 40 && consumed.size() == 0; i++) cyc(1);
        if (i == 40) timeout_fail("wait_after_drain");
        chk_consumed("after_flush_pc", 0, 8'h40, 16'h1040);
        chk("drain_no_advance", pcadv_pulses - p0, 1);

        // Flush coinciding with ack while one entry is buffered
        p_ready = 0;
        fixed_lat = 1;
        do_reset();
        wait_issue_at_count(1, "wait_flush_ack");
        lat_cur      = 0;
        force_flush  = 1;
        force_target = 8'h80;
        p0 = pcadv_pulses;
        cyc(1);
        chk("flushack_valid", bus.InstrValid, 0);
        chk("flushack_state", dut.r_state, ST_IDLE);
        chk("flushack_pulses", pcadv_pulses - p0, 0);

        // Reset in the middle of WAIT, then a stray ack
        p_ready = 100;
        fixed_lat = 100;
        do_reset();
        wait_issue_at_count(0, "wait_rst_issue");
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        consumed.delete();
        fixed_lat = 1;
        stray_ack = 1;
        p0 = pcadv_pulses;
        chk("midrst_req", bus.ImemReq, 0);
        chk("midrst_valid", bus.InstrValid, 0);
        cyc(1);
        chk("stray_ack_pulses", pcadv_pulses - p0, 0);
        cyc(10);
        chk_consumed("after_rst_0", 0, 8'h00, 16'h1000);

        // Push and pop in the same cycle at count 1
        p_ready = 0;
        fixed_lat = 1;
        do_reset();
        wait_issue_at_count(1, "wait_pushpop");
        lat_cur = 0;
        p_ready = 100;
        cyc(1);
        chk("pushpop_count", dut.w_count, 1);
        chk("pushpop_head_pc", bus.InstrPC, 8'h01);
        chk("pushpop_head_ins", bus.Instr, 16'h1001);
        cyc(10);
        chk_consumed("pushpop_0", 0, 8'h00, 16'h1000);
        chk_consumed("pushpop_1", 1, 8'h01, 16'h1001);
        chk_consumed("pushpop_2", 2, 8'h02, 16'h1002);

        // Randomized traffic with random data, latencies, flushes, resets
        for (int k = 0; k < 256; k++) mem[k] = INSTR_N'($urandom);
        fixed_lat = -1;
        p_flush   = 4;
        do_reset();
        repeat (4) begin
            p_ready = int'($urandom_range(20, 100));
            cyc(700);
            rst = 1'b1;
            cyc(1);
            rst = 1'b0;
        end
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : b_watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
